// File: rtl/imem_loader.sv
// imem_loader
// -----------
// Loads the instruction memory from a byte stream while holding the MIPS core
// in reset. Bytes arrive most-significant first and are packed into 32-bit
// words. Each word is written to the next word-aligned address starting at
// BASE_ADDR. When the requested number of words has been written, the core is
// released.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; returns to IDLE, partial word dropped
//   start       load request, sampled only in IDLE or DONE
//   word_count  words to load (ADDR_WIDTH+1 bits), captured on an accepted start
//   byte_valid  byte_data carries a byte this cycle
//   byte_data   stream byte, MSB of each word first
//   byte_ready  loader consumes a byte this cycle (LOAD state only)
//   imem_we     one-cycle write strobe to instruction memory
//   imem_addr   byte address of the write, always word aligned
//   imem_wdata  word being written
//   cpu_reset   core reset, low only once a load has completed
//   busy        load in progress (LOAD or WRITE)
//   done        last load completed, core released
//   error       last start was rejected because word_count exceeded DEPTH
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Largest legal word_count; fits exactly in the ADDR_WIDTH+1 bit field.
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   index_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           word_q;
    logic                  error_q;

    logic [ADDR_WIDTH:0]   index_d;
    logic [31:0]           word_d;
    logic [1:0]            byte_cnt_d;

    always_comb begin
        index_d    = index_q + 1'b1;
        word_d     = {word_q[23:0], byte_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE share start handling; a rejected start leaves
                // the state alone so DONE keeps the core running.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (word_count > DEPTH) begin
                            error_q <= 1'b1;
                        end else begin
                            error_q    <= 1'b0;
                            count_q    <= word_count;
                            index_q    <= '0;
                            byte_cnt_q <= '0;
                            state_q    <= (word_count == '0) ? S_DONE : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (byte_valid) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_d;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    index_q <= index_d;
                    state_q <= (index_d == count_q) ? S_DONE : S_LOAD;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs decode from registers only; no input reaches an output
    // combinationally.
    assign byte_ready = (state_q == S_LOAD);
    assign imem_we    = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign cpu_reset  = (state_q != S_DONE);
    assign error      = error_q;
    assign imem_wdata = word_q;
    // Word index scaled to a byte address in 32 bits so it never wraps.
    assign imem_addr  = BASE_ADDR + {{(29 - ADDR_WIDTH){1'b0}}, index_q, 2'b00};

endmodule
